// File: rtl/uart_boot_loader_if.sv
// Byte-stream input from the UART receiver and word-write port towards the
// data RAM, bundled so the loader and its environment share one definition.
interface uart_boot_loader_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_LEN = 14
);
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  ram_wr_en;
  logic [ADDR_LEN-1:0]   ram_addr;
  logic [XLEN-1:0]       ram_wr_data;
  logic [XLEN/8-1:0]     ram_we;

  // Loader side: consumes UART bytes, drives the RAM write port.
  modport master (
    input  rx_valid,
    input  rx_byte,
    output ram_wr_en,
    output ram_addr,
    output ram_wr_data,
    output ram_we
  );

  // Environment side: UART receiver plus RAM.
  modport slave (
    output rx_valid,
    output rx_byte,
    input  ram_wr_en,
    input  ram_addr,
    input  ram_wr_data,
    input  ram_we
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Software-upgrade loader. Receives SYNC, LEN_LO, LEN_HI, LEN*4 data bytes and
// an 8-bit additive checksum, packs data little-endian into 32-bit words and
// writes them to RAM from word address 0. during_sw_upgrade keeps the core in
// reset from the request until the host releases upgrade mode.
// The 16-bit length field limits ADDR_LEN to at most 15.
module uart_boot_loader #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_LEN    = 14,
  parameter int unsigned TIMEOUT_CYC = 5000000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upgrade_req_b,
  uart_boot_loader_if.master  bus,
  output logic                during_sw_upgrade,
  output logic                done,
  output logic                err
);

  localparam int unsigned TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned LEN_MAX = 1 << ADDR_LEN;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t              state_q;
  logic                req_s1_q;
  logic                req_s2_q;
  logic                during_q;
  logic                done_q;
  logic                err_q;
  logic                wr_en_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [XLEN-1:0]     wr_data_q;
  logic [XLEN/8-1:0]   we_q;
  logic [7:0]          len_lo_q;
  logic [ADDR_LEN:0]   len_q;
  logic [ADDR_LEN-1:0] word_idx_q;
  logic [1:0]          lane_q;
  logic [XLEN-9:0]     word_q;
  logic [7:0]          csum_q;
  logic [TW-1:0]       tmo_q;

  logic [15:0]         len_d;
  logic [ADDR_LEN:0]   idx_next_d;
  logic [XLEN-1:0]     word_d;
  logic                req_active_d;

  // Combinational helpers for the frame FSM.
  always_comb begin
    len_d        = {bus.rx_byte, len_lo_q};
    idx_next_d   = {1'b0, word_idx_q} + (ADDR_LEN+1)'(1);
    word_d       = {bus.rx_byte, word_q};
    req_active_d = ~req_s2_q;
  end

  // Request synchroniser, frame FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_s1_q   <= 1'b1;
      req_s2_q   <= 1'b1;
      during_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      we_q       <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
    end else begin
      req_s1_q <= upgrade_req_b;
      req_s2_q <= req_s1_q;
      // The write strobe is a single-cycle pulse; an already-issued strobe is
      // visible for its cycle regardless of an abort taken on the next edge.
      wr_en_q  <= 1'b0;
      we_q     <= '0;

      case (state_q)
        ST_IDLE: begin
          if (req_active_d) begin
            state_q    <= ST_SYNC;
            during_q   <= 1'b1;
            csum_q     <= '0;
            word_idx_q <= '0;
            lane_q     <= '0;
            tmo_q      <= '0;
          end
        end

        ST_DONE, ST_ERR: begin
          if (!req_active_d) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            during_q <= 1'b0;
          end
        end

        default: begin
          // Abort has priority over a byte arriving in the same cycle.
          if (!req_active_d) begin
            state_q  <= ST_IDLE;
            during_q <= 1'b0;
          end else if (bus.rx_valid) begin
            tmo_q <= '0;
            case (state_q)
              ST_SYNC: begin
                if (bus.rx_byte == SYNC_BYTE) state_q <= ST_LEN0;
              end
              ST_LEN0: begin
                len_lo_q <= bus.rx_byte;
                state_q  <= ST_LEN1;
              end
              ST_LEN1: begin
                len_q <= len_d[ADDR_LEN:0];
                if (32'(len_d) > LEN_MAX) begin
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
                end else if (len_d == '0) begin
                  state_q <= ST_CSUM;
                end else begin
                  state_q <= ST_DATA;
                end
              end
              ST_DATA: begin
                csum_q <= csum_q + bus.rx_byte;
                lane_q <= lane_q + 2'd1;
                case (lane_q)
                  2'd0: word_q[7:0]   <= bus.rx_byte;
                  2'd1: word_q[15:8]  <= bus.rx_byte;
                  2'd2: word_q[23:16] <= bus.rx_byte;
                  default: begin
                    wr_en_q    <= 1'b1;
                    we_q       <= '1;
                    wr_data_q  <= word_d;
                    addr_q     <= word_idx_q;
                    word_idx_q <= idx_next_d[ADDR_LEN-1:0];
                    if (idx_next_d == len_q) state_q <= ST_CSUM;
                  end
                endcase
              end
              ST_CSUM: begin
                if (bus.rx_byte == csum_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (state_q != ST_SYNC) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
        end
      endcase
    end
  end

  assign during_sw_upgrade = during_q;
  assign done              = done_q;
  assign err               = err_q;
  assign bus.ram_wr_en     = wr_en_q;
  assign bus.ram_addr      = addr_q;
  assign bus.ram_wr_data   = wr_data_q;
  assign bus.ram_we        = we_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: framed uploads, checksum failure,
// noise before SYNC with back-to-back data, timeout, length bound, zero
// length, abort and mid-frame reset.
module tb_uart_boot_loader;
  localparam int unsigned TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic upgrade_req_b = 1'b1;
  logic during_sw_upgrade, done, err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  uart_boot_loader_if #(.XLEN(32), .ADDR_LEN(14)) bus_if ();

  uart_boot_loader #(
    .XLEN(32), .ADDR_LEN(14), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .upgrade_req_b(upgrade_req_b), .bus(bus_if),
    .during_sw_upgrade(during_sw_upgrade), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled on the falling edge.
  int unsigned wr_cnt = 0;
  int unsigned wr_cyc_last = 0;
  logic [13:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [3:0]  wr_we   [64];
  always @(negedge clk) begin
    if (bus_if.ram_wr_en === 1'b1) begin
      wr_addr[wr_cnt[5:0]] <= bus_if.ram_addr;
      wr_data[wr_cnt[5:0]] <= bus_if.ram_wr_data;
      wr_we[wr_cnt[5:0]]   <= bus_if.ram_we;
      wr_cyc_last          <= cyc;
      wr_cnt               <= wr_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_byte  = b;
    tick(1);
    bus_if.rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic start_req();
    upgrade_req_b = 1'b0;
    tick(4);
  endtask

  task automatic release_req();
    upgrade_req_b = 1'b1;
    tick(4);
  endtask

  task automatic send_frame2(input logic [7:0] cs);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    send(cs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    upgrade_req_b = 1'b1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_byte = 8'h00;
    tick(3);
    total++; if (during_sw_upgrade !== 1'b0) begin bad++; $display("FAIL reset_during got=%b want=0", during_sw_upgrade); end
    total++; if (bus_if.ram_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus_if.ram_wr_en); end
    total++; if (bus_if.ram_addr !== 14'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus_if.ram_addr); end
    total++; if (bus_if.ram_wr_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus_if.ram_wr_data); end
    total++; if (bus_if.ram_we !== 4'h0) begin bad++; $display("FAIL reset_we got=%h want=0", bus_if.ram_we); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL reset_done_err got=%b want=00", {done, err}); end
    rst = 1'b0;
    tick(2);
  endtask

  // Checksum of 11..88 is 0x11*36 = 0x264 -> 0x64.
  task automatic test_good_frame();
    int unsigned base;
    base = wr_cnt;
    start_req();
    total++; if (during_sw_upgrade !== 1'b1) begin bad++; $display("FAIL good_during got=%b want=1", during_sw_upgrade); end
    send_frame2(8'h64);
    tick(2);
    total++; if (wr_cnt - base !== 2) begin bad++; $display("FAIL good_nwr got=%0d want=2", wr_cnt - base); end
    total++; if (wr_data[base[5:0]] !== 32'h44332211) begin bad++; $display("FAIL good_w0 got=%h want=44332211", wr_data[base[5:0]]); end
    total++; if (wr_addr[base[5:0]] !== 14'd0) begin bad++; $display("FAIL good_a0 got=%h want=0", wr_addr[base[5:0]]); end
    total++; if (wr_data[(base+1)%64] !== 32'h88776655) begin bad++; $display("FAIL good_w1 got=%h want=88776655", wr_data[(base+1)%64]); end
    total++; if (wr_addr[(base+1)%64] !== 14'd1) begin bad++; $display("FAIL good_a1 got=%h want=1", wr_addr[(base+1)%64]); end
    total++; if (wr_we[base[5:0]] !== 4'hF) begin bad++; $display("FAIL good_we got=%h want=F", wr_we[base[5:0]]); end
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL good_done_err got=%b want=10", {done, err}); end
    total++; if (bus_if.ram_we !== 4'h0) begin bad++; $display("FAIL good_we_idle got=%h want=0", bus_if.ram_we); end
    release_req();
    total++; if ({during_sw_upgrade, done, err} !== 3'b000) begin bad++; $display("FAIL good_release got=%b want=000", {during_sw_upgrade, done, err}); end
  endtask

  task automatic test_bad_checksum();
    int unsigned base;
    base = wr_cnt;
    start_req();
    send_frame2(8'hCC);
    tick(2);
    total++; if (wr_cnt - base !== 2) begin bad++; $display("FAIL badcs_nwr got=%0d want=2", wr_cnt - base); end
    total++; if ({done, err} !== 2'b01) begin bad++; $display("FAIL badcs_done_err got=%b want=01", {done, err}); end
    total++; if (during_sw_upgrade !== 1'b1) begin bad++; $display("FAIL badcs_during got=%b want=1", during_sw_upgrade); end
    release_req();
    total++; if ({during_sw_upgrade, done, err} !== 3'b000) begin bad++; $display("FAIL badcs_release got=%b want=000", {during_sw_upgrade, done, err}); end
  endtask

  task automatic test_back_to_back();
    int unsigned base, c4;
    logic [7:0] b [4];
    b[0] = 8'h01; b[1] = 8'h02; b[2] = 8'h03; b[3] = 8'h04;
    c4 = 0;
    base = wr_cnt;
    start_req();
    send(8'h00); send(8'h7F); send(8'hA5); send(8'h01); send(8'h00);
    for (int i = 0; i < 4; i++) begin
      bus_if.rx_valid = 1'b1;
      bus_if.rx_byte  = b[i];
      if (i == 3) c4 = cyc;
      tick(1);
    end
    bus_if.rx_valid = 1'b0;
    tick(3);
    total++; if (wr_cnt - base !== 1) begin bad++; $display("FAIL b2b_nwr got=%0d want=1", wr_cnt - base); end
    total++; if (wr_data[base[5:0]] !== 32'h04030201) begin bad++; $display("FAIL b2b_data got=%h want=04030201", wr_data[base[5:0]]); end
    total++; if (wr_addr[base[5:0]] !== 14'd0) begin bad++; $display("FAIL b2b_addr got=%h want=0", wr_addr[base[5:0]]); end
    total++; if (wr_cyc_last !== c4 + 1) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", wr_cyc_last, c4 + 1); end
    send(8'h0A);
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL b2b_done_err got=%b want=10", {done, err}); end
    release_req();
  endtask

  task automatic test_timeout();
    int unsigned base;
    base = wr_cnt;
    start_req();
    send(8'hA5); send(8'h01); send(8'h00); send(8'hAA);
    tick(20);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", err); end
    tick(25);
    total++; if ({done, err} !== 2'b01) begin bad++; $display("FAIL tmo_err got=%b want=01", {done, err}); end
    send(8'hBB); send(8'hCC); send(8'hDD);
    tick(2);
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL tmo_nwr got=%0d want=0", wr_cnt - base); end
    release_req();
  endtask

  task automatic test_len_bound();
    int unsigned base;
    base = wr_cnt;
    start_req();
    send(8'hA5); send(8'h01); send(8'h40);
    total++; if ({done, err} !== 2'b01) begin bad++; $display("FAIL len_err got=%b want=01", {done, err}); end
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    tick(2);
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL len_nwr got=%0d want=0", wr_cnt - base); end
    release_req();
    start_req();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL len0_done got=%b want=10", {done, err}); end
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL len0_nwr got=%0d want=0", wr_cnt - base); end
    release_req();
  endtask

  task automatic test_abort();
    int unsigned base;
    base = wr_cnt;
    start_req();
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    release_req();
    total++; if ({during_sw_upgrade, done, err} !== 3'b000) begin bad++; $display("FAIL abort_state got=%b want=000", {during_sw_upgrade, done, err}); end
    send(8'h33); send(8'h44);
    tick(2);
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL abort_nwr got=%0d want=0", wr_cnt - base); end
  endtask

  task automatic test_rst_mid_data();
    int unsigned base;
    base = wr_cnt;
    start_req();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    rst = 1'b1;
    tick(1);
    total++; if ({during_sw_upgrade, done, err, bus_if.ram_wr_en} !== 4'b0000) begin bad++; $display("FAIL rst_outs got=%b want=0000", {during_sw_upgrade, done, err, bus_if.ram_wr_en}); end
    upgrade_req_b = 1'b1;
    tick(1);
    rst = 1'b0;
    send(8'h44); send(8'h55);
    tick(2);
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL rst_nwr got=%0d want=0", wr_cnt - base); end
    total++; if (during_sw_upgrade !== 1'b0) begin bad++; $display("FAIL rst_during got=%b want=0", during_sw_upgrade); end
  endtask

  initial begin
    bus_if.rx_valid = 1'b0;
    bus_if.rx_byte  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_back_to_back();
    test_timeout();
    test_len_bound();
    test_abort();
    test_rst_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
